// File: rtl/obi_sram_slave.sv
// obi_sram_slave: flop-array OBI responder with byte-enable writes and an
// in-order response FIFO that honours rready backpressure.
// Optional feature macro: OBI_SRAM_SLAVE_ZERO_INIT_EN (zero the memory after reset).
module obi_sram_slave #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned Depth     = 256,
  parameter int unsigned RspDepth  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   we_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [IdWidth-1:0]     aid_i,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic [DataWidth-1:0]   rdata_o,
  output logic [IdWidth-1:0]     rid_o
);

  localparam int unsigned NumBytes = DataWidth / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned IdxW     = $clog2(Depth);
  localparam int unsigned CntW     = $clog2(RspDepth + 1);
  localparam int unsigned PtrW     = (RspDepth > 1) ? $clog2(RspDepth) : 1;

  typedef enum logic {
    INIT,
    READY
  } state_e;

  state_e state_q, state_d;

  logic [DataWidth-1:0] mem_q [Depth];
  logic [IdxW-1:0]      req_idx;
  logic                 mem_we;
  logic [IdxW-1:0]      mem_widx;
  logic [DataWidth-1:0] mem_wdata;
  logic [NumBytes-1:0]  mem_wbe;

  logic [DataWidth-1:0] rsp_data_q [RspDepth];
  logic [IdWidth-1:0]   rsp_id_q   [RspDepth];
  logic [DataWidth-1:0] rsp_wdata;
  logic [PtrW-1:0]      wptr_q, wptr_d;
  logic [PtrW-1:0]      rptr_q, rptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 push;
  logic                 pop;

`ifdef OBI_SRAM_SLAVE_ZERO_INIT_EN
  logic [IdxW-1:0]      init_idx_q, init_idx_d;
`endif

  // Upper address bits and sub-word offset bits are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^addr_i;

  assign req_idx = addr_i[OffW +: IdxW];

  // Grant never looks at rready, so a full FIFO blocks even on a pop cycle.
  assign gnt_o = req_i && !rst_i && (state_q == READY) && (count_q < CntW'(RspDepth));
  assign push  = gnt_o;
  assign pop   = rvalid_o && rready_i;

  // Next state and memory write port: zero-fill during INIT, master writes in READY.
  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_widx  = req_idx;
    mem_wdata = wdata_i;
    mem_wbe   = be_i;
`ifdef OBI_SRAM_SLAVE_ZERO_INIT_EN
    init_idx_d = init_idx_q;
`endif
    case (state_q)
      INIT: begin
`ifdef OBI_SRAM_SLAVE_ZERO_INIT_EN
        mem_we     = 1'b1;
        mem_widx   = init_idx_q;
        mem_wdata  = '0;
        mem_wbe    = '1;
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == IdxW'(Depth - 1)) begin
          state_d = READY;
        end
`else
        state_d = READY;
`endif
      end
      READY: begin
        mem_we = gnt_o && we_i;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // FIFO pointer and occupancy bookkeeping; pointers wrap at RspDepth.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = (wptr_q == PtrW'(RspDepth - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrW'(RspDepth - 1)) ? '0 : rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Write responses carry zero data; reads sample the array in the grant cycle.
  assign rsp_wdata = we_i ? '0 : mem_q[req_idx];

  // Control state with synchronous reset; queued responses are discarded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
`ifdef OBI_SRAM_SLAVE_ZERO_INIT_EN
      init_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
`ifdef OBI_SRAM_SLAVE_ZERO_INIT_EN
      init_idx_q <= init_idx_d;
`endif
    end
  end

  // Memory array with per-byte-lane write enables; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (mem_wbe[b]) begin
          mem_q[mem_widx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Response storage; validity is tracked solely by count_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      rsp_data_q[wptr_q] <= rsp_wdata;
      rsp_id_q[wptr_q]   <= aid_i;
    end
  end

  assign rvalid_o = (count_q != '0);
  assign rdata_o  = rvalid_o ? rsp_data_q[rptr_q] : '0;
  assign rid_o    = rvalid_o ? rsp_id_q[rptr_q]   : '0;

endmodule
